// File: rtl/vc_arb_pkg.sv
// vc_arb_pkg: shared constants and state encoding for the virtual-channel arbiter
package vc_arb_pkg;
   localparam int NUM_VC = 4;
   localparam int VC_W = 2;
   localparam logic [VC_W-1:0] VCHANEL0 = 2'b00;
   localparam logic [VC_W-1:0] VCHANEL1 = 2'b01;
   localparam logic [VC_W-1:0] VCHANEL2 = 2'b10;
   localparam logic [VC_W-1:0] VCHANEL3 = 2'b11;
   typedef enum logic {IDLE = 1'b0, SERVE = 1'b1} state_t;
endpackage

// File: rtl/vc_rr_select.sv
// vc_rr_select: combinational round-robin picker, searching from last_vc+1 upward modulo NUM_VC
module vc_rr_select
   import vc_arb_pkg::*;
(
   input  logic [NUM_VC-1:0] elig,
   input  logic [VC_W-1:0]   last_vc,
   output logic [VC_W-1:0]   winner,
   output logic              any
);
   logic [VC_W-1:0] cand;
   // Walk offsets from farthest to nearest so the nearest eligible VC is written last.
   always_comb begin
      winner = VCHANEL0;
      cand = VCHANEL0;
      for (int i = NUM_VC; i >= 1; i--) begin
         cand = last_vc + VC_W'(i);
         if (elig[cand]) winner = cand;
      end
   end
   assign any = |elig;
endmodule

// File: rtl/vc_arbiter.sv
// vc_arbiter: shares one output path among four VC FIFOs using a schedule hint,
// round-robin fallback, starvation override and bounded bursts.
module vc_arbiter
   import vc_arb_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int BURST_MAX = 4,
   parameter int STARVE_LIMIT = 15,
   parameter int CNT_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enb,
   input  logic [VC_W-1:0]   sched_vc,
   input  logic [NUM_VC-1:0] vc_empty,
   input  logic [DATA_W-1:0] vc_data0,
   input  logic [DATA_W-1:0] vc_data1,
   input  logic [DATA_W-1:0] vc_data2,
   input  logic [DATA_W-1:0] vc_data3,
   input  logic              out_full,
   output logic [NUM_VC-1:0] pop,
   output logic [DATA_W-1:0] data_out,
   output logic              valid_out,
   output logic [VC_W-1:0]   grant_vc,
   output logic              grant_active
);
   localparam int BC_W = $clog2(BURST_MAX + 1);
   state_t state, state_nx;
   logic [VC_W-1:0] last_vc, rr_win, winner, starve_vc;
   logic [BC_W-1:0] burst_cnt;
   logic [CNT_W-1:0] starve [NUM_VC];
   logic [NUM_VC-1:0] elig;
   logic [DATA_W-1:0] sel_data;
   logic rr_any, starved_any, decide, popping, last_pop, exit_srv;

   assign elig = ~vc_empty;

   vc_rr_select u_rr (
      .elig    (elig),
      .last_vc (last_vc),
      .winner  (rr_win),
      .any     (rr_any)
   );

   // Lowest-index requesting VC at the limit wins; scan high to low so the lowest lands last.
   always_comb begin
      starved_any = 1'b0;
      starve_vc = VCHANEL0;
      for (int i = NUM_VC - 1; i >= 0; i--)
         if (elig[i] && starve[i] == CNT_W'(STARVE_LIMIT)) begin
            starved_any = 1'b1;
            starve_vc = VC_W'(i);
         end
   end

   assign winner = starved_any ? starve_vc : elig[sched_vc] ? sched_vc : rr_win;
   assign decide = (state == IDLE) & enb & ~out_full & rr_any;
   assign popping = (state == SERVE) & enb & ~rst & ~out_full & ~vc_empty[grant_vc];
   assign pop = popping ? NUM_VC'(1) << grant_vc : '0;
   assign last_pop = popping & (burst_cnt == BC_W'(BURST_MAX - 1));
   assign exit_srv = (state == SERVE) & enb & (last_pop | (vc_empty[grant_vc] & ~popping));
   assign sel_data = grant_vc == VCHANEL0 ? vc_data0 :
                     grant_vc == VCHANEL1 ? vc_data1 :
                     grant_vc == VCHANEL2 ? vc_data2 : vc_data3;

   always_comb state_nx = decide ? SERVE : exit_srv ? IDLE : state;

   always_ff @(posedge clk)
      if (rst) state <= IDLE;
      else state <= state_nx;

   always_ff @(posedge clk) begin
      if (rst) begin
         last_vc <= VCHANEL3;
         grant_vc <= VCHANEL0;
         grant_active <= 1'b0;
         burst_cnt <= '0;
         data_out <= '0;
         valid_out <= 1'b0;
         for (int i = 0; i < NUM_VC; i++) starve[i] <= '0;
      end else begin
         valid_out <= popping;
         if (popping) begin
            data_out <= sel_data;
            burst_cnt <= burst_cnt + BC_W'(1);
         end
         if (decide) begin
            grant_vc <= winner;
            grant_active <= 1'b1;
            burst_cnt <= '0;
         end
         if (exit_srv) begin
            grant_active <= 1'b0;
            last_vc <= grant_vc;
         end
         // Waiting VCs age; the VC in service and any idle VC do not.
         if (enb)
            for (int i = 0; i < NUM_VC; i++)
               starve[i] <= ((decide && winner == VC_W'(i)) || !elig[i]) ? '0 :
                            ((grant_active && grant_vc == VC_W'(i)) || starve[i] == CNT_W'(STARVE_LIMIT)) ?
                            starve[i] : starve[i] + CNT_W'(1);
      end
   end
endmodule

// File: tb/tb_vc_arbiter.sv
// tb_vc_arbiter: directed scenarios with queue-model FIFOs; a monitor scores every valid_out word.
module tb_vc_arbiter;
   logic clk = 1'b0;
   logic rst, enb, out_full;
   logic [1:0] sched_vc;
   logic [3:0] vc_empty = 4'hF;
   logic [7:0] vc_data0 = 8'h00, vc_data1 = 8'h00, vc_data2 = 8'h00, vc_data3 = 8'h00;
   logic [3:0] pop;
   logic [7:0] data_out;
   logic valid_out;
   logic [1:0] grant_vc;
   logic grant_active;
   logic [7:0] fq [4][$];
   logic [9:0] exp_q [$];
   int errors = 0;
   int checks = 0;

   vc_arbiter dut (
      .clk          (clk),
      .rst          (rst),
      .enb          (enb),
      .sched_vc     (sched_vc),
      .vc_empty     (vc_empty),
      .vc_data0     (vc_data0),
      .vc_data1     (vc_data1),
      .vc_data2     (vc_data2),
      .vc_data3     (vc_data3),
      .out_full     (out_full),
      .pop          (pop),
      .data_out     (data_out),
      .valid_out    (valid_out),
      .grant_vc     (grant_vc),
      .grant_active (grant_active)
   );

   always #5 clk = ~clk;

   // First-word-fall-through FIFO model: pop on the edge, present the new head 1 time unit later.
   always @(posedge clk) begin
      for (int v = 0; v < 4; v++)
         if (pop[v] && fq[v].size() > 0) void'(fq[v].pop_front());
      #1;
      for (int v = 0; v < 4; v++) vc_empty[v] = (fq[v].size() == 0);
      vc_data0 = fq[0].size() > 0 ? fq[0][0] : 8'h00;
      vc_data1 = fq[1].size() > 0 ? fq[1][0] : 8'h00;
      vc_data2 = fq[2].size() > 0 ? fq[2][0] : 8'h00;
      vc_data3 = fq[3].size() > 0 ? fq[3][0] : 8'h00;
   end

   initial forever begin
      @(negedge clk);
      if (valid_out === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected: got vc %0d data %0h, nothing expected", grant_vc, data_out);
         end else begin
            logic [9:0] e;
            e = exp_q.pop_front();
            if ({grant_vc, data_out} !== e) begin
               errors++;
               $display("FAIL sb_word: got vc %0d data %0h, expected vc %0d data %0h", grant_vc, data_out, e[9:8], e[7:0]);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] word(input int v, input int i);
      return 8'((v + 1) * 16 + i);
   endfunction

   task automatic load(input int v, input int n);
      for (int i = 0; i < n; i++) fq[v].push_back(word(v, i));
   endtask

   task automatic expect_words(input int v, input int first, input int n);
      for (int i = 0; i < n; i++) exp_q.push_back({2'(v), word(v, first + i)});
   endtask

   task automatic reset_dut(input logic [1:0] s);
      rst = 1'b1;
      enb = 1'b1;
      out_full = 1'b0;
      sched_vc = s;
      for (int v = 0; v < 4; v++) fq[v].delete();
      exp_q.delete();
   endtask

   task automatic go();
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
      repeat (4) @(negedge clk);
      chk(name, exp_q.size(), 0);
   endtask

   initial begin
      rst = 1'b1;
      enb = 1'b1;
      out_full = 1'b0;
      sched_vc = 2'd0;
      repeat (2) @(negedge clk);
      chk("rst_pop", pop, 0);
      chk("rst_valid", valid_out, 0);
      chk("rst_gact", grant_active, 0);
      chk("rst_data", data_out, 0);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("idle_pop", pop, 0);
         chk("idle_valid", valid_out, 0);
         chk("idle_gact", grant_active, 0);
         chk("idle_data", data_out, 0);
      end

      // Hint honoured: VC2 gets a full four-word burst, then one decision cycle.
      reset_dut(2'd2);
      for (int v = 0; v < 4; v++) load(v, 6);
      expect_words(2, 0, 4);
      go();
      @(negedge clk);
      chk("hint_valid_early", valid_out, 0);
      for (int i = 0; i < 4; i++) begin
         chk("hint_pop", pop, 4'b0100);
         chk("hint_gvc", grant_vc, 2);
         @(negedge clk);
      end
      chk("hint_idle_pop", pop, 0);
      chk("hint_idle_gact", grant_active, 0);
      rst = 1'b1;
      @(negedge clk);
      chk("hint_sb_done", exp_q.size(), 0);

      // Hint not eligible: round-robin from VC3 lands on VC0, then VC1 after last_vc=0.
      reset_dut(2'd3);
      load(0, 2);
      expect_words(0, 0, 2);
      go();
      @(negedge clk);
      chk("rr_gvc", grant_vc, 0);
      chk("rr_pop", pop, 4'b0001);
      repeat (2) @(negedge clk);
      chk("rr_empty_pop", pop, 0);
      @(negedge clk);
      chk("rr_exit", grant_active, 0);
      fq[0].push_back(8'h12);
      fq[1].push_back(8'h20);
      exp_q.push_back({2'd1, 8'h20});
      exp_q.push_back({2'd0, 8'h12});
      drain("rr_drain");

      // Backpressure mid-burst for three cycles.
      reset_dut(2'd3);
      load(3, 6);
      expect_words(3, 0, 6);
      go();
      repeat (2) @(negedge clk);
      out_full = 1'b1;
      #1 chk("bp_pop_stall", pop, 0);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("bp_pop", pop, 0);
         chk("bp_valid", valid_out, 0);
      end
      @(negedge clk);
      out_full = 1'b0;
      repeat (2) @(negedge clk);
      chk("bp_still_serving", grant_active, 1);
      @(negedge clk);
      chk("bp_exit_after_four", grant_active, 0);
      drain("bp_drain");

      // Starvation: VC1 wins after 15 waiting cycles despite the hint pointing at VC0.
      reset_dut(2'd0);
      load(0, 16);
      load(1, 4);
      expect_words(0, 0, 12);
      expect_words(1, 0, 4);
      expect_words(0, 12, 4);
      go();
      drain("starve_drain");

      // Reset during the second pop cycle.
      reset_dut(2'd2);
      load(2, 6);
      expect_words(2, 0, 6);
      go();
      repeat (2) @(negedge clk);
      rst = 1'b1;
      #1 chk("rstmid_pop", pop, 0);
      @(negedge clk);
      rst = 1'b0;
      chk("rstmid_gact", grant_active, 0);
      chk("rstmid_valid", valid_out, 0);
      chk("rstmid_data", data_out, 0);
      drain("rstmid_drain");

      // Enable freeze during SERVE.
      reset_dut(2'd1);
      load(1, 5);
      expect_words(1, 0, 5);
      go();
      repeat (2) @(negedge clk);
      enb = 1'b0;
      #1 chk("frz_pop", pop, 0);
      chk("frz_gvc", grant_vc, 1);
      @(negedge clk);
      chk("frz_valid", valid_out, 0);
      chk("frz_gact", grant_active, 1);
      @(negedge clk);
      enb = 1'b1;
      #1 chk("frz_resume_pop", pop, 4'b0010);
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      chk("frz_exit_after_four", grant_active, 0);
      drain("frz_drain");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/vc_arbiter.md
Name: vc_arbiter

Overview:
- Shares the single downstream output path between four virtual-channel input FIFOs (VC0..VC3).
- Each arbitration decision takes the 2-bit scheduled VC from the priority-table sequencer (`arbiter_input`, driven into `sched_vc`) as its primary hint.
- Falls back to round-robin when the hinted VC has no data, and forces service of any VC that has waited too long.
- Once granted, a VC is held for a bounded burst, popped from its FIFO and forwarded, registered, to the output.

Parameters:
- DATA_W, 8, width of each FIFO word and of `data_out`.
- BURST_MAX, 4, maximum words popped per grant (must be ≥1).
- STARVE_LIMIT, 15, wait-cycle count at which a requesting VC is forced to win (must fit in CNT_W).
- CNT_W, 4, width of each starvation counter.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- enb  in  1  global enable; low freezes all state
- sched_vc  in  2  scheduled VC for this cycle, from the priority-table sequencer
- vc_empty  in  4  per-VC FIFO empty flags; bit v = VCv
- vc_data0..vc_data3  in  DATA_W each  head word of each FIFO (first-word-fall-through)
- out_full  in  1  downstream almost-full; blocks popping
- pop  out  4  one-hot FIFO read strobe
- data_out  out  DATA_W  forwarded word, registered
- valid_out  out  1  data_out is valid this cycle
- grant_vc  out  2  currently granted VC
- grant_active  out  1  high while in SERVE

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE; pop=0; data_out=0; valid_out=0; grant_vc=0; grant_active=0.
  - last_vc=3, so round-robin starts at VC0. All starvation counters=0; burst_cnt=0.
  - rst has priority over everything. pop is gated by !rst in the same cycle, so a burst aborts with no pop.
- enb=0: state, counters and grant hold; pop=0; valid_out<=0 at the next edge.
- Eligibility: elig[v] = ~vc_empty[v].
- IDLE, with enb=1, out_full=0 and elig≠0, the winner is the first rule that applies:
  1. the lowest-index VC whose starve_cnt == STARVE_LIMIT;
  2. else sched_vc, if elig[sched_vc]=1;
  3. else the first eligible VC searching last_vc+1, last_vc+2, … modulo 4.
  - On a decision, at the next edge: grant_vc<=winner, grant_active<=1, burst_cnt<=0, state<=SERVE.
  - No pop occurs in the IDLE cycle.
  - If elig=0 or out_full=1, remain in IDLE.
- SERVE:
  - pop[grant_vc] = enb & ~rst & ~out_full & ~vc_empty[grant_vc]. It is combinational; every other pop bit is 0.
  - On pop: data_out<=vc_dataN[grant_vc], valid_out<=1, burst_cnt<=burst_cnt+1. Otherwise valid_out<=0.
  - Exit to IDLE (grant_active<=0, last_vc<=grant_vc) when either:
    - a pop occurs with burst_cnt==BURST_MAX-1; or
    - vc_empty[grant_vc]=1 while not popping.
  - out_full=1 stalls in SERVE with no pop and no exit.
- Latency:
  - Request seen in IDLE → decision at edge 1 → first pop in cycle 2 → valid_out high in cycle 3.
  - Back-to-back bursts always incur one idle (decision) cycle.
- Starvation counters, updated only when enb=1:
  - counter v resets to 0 when VCv becomes the winner, or when elig[v]=0;
  - otherwise it increments, saturating at STARVE_LIMIT, while elig[v]=1 and VCv is not the current grant.
- Width rules:
  - burst_cnt is ceil(log2(BURST_MAX+1)) bits.
  - All VC index arithmetic is 2-bit, wrapping naturally.

Decomposition:
- Package vc_arb_pkg holds:
  - NUM_VC=4 and VC_W=2;
  - the VCHANEL0..3 constants (2'b00..2'b11);
  - the state encodings IDLE=1'b0 and SERVE=1'b1.
- One sub-module: vc_rr_select, a combinational round-robin picker.
  - Inputs: elig[3:0], last_vc[1:0].
  - Outputs: winner[1:0], any.
  - The top level instantiates it for rule 3.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, vc_empty=4'b1111 → pop=0, valid_out=0, grant_active=0, data_out=0 throughout.
- Hint honoured: vc_empty=4'b0000, sched_vc=2'b10, each FIFO holding 6 words → grant_vc=2, four pops of VC2 (pop=4'b0100), valid_out high for 4 consecutive cycles starting 2 cycles after the first pop decision, then one IDLE cycle.
- Hint not eligible: vc_empty=4'b1110, sched_vc=2'b11, last_vc=3 → round-robin picks VC0; VC0 holding 2 words → 2 pops, exit on empty, last_vc=0.
- Backpressure: mid-burst out_full=1 for 3 cycles → pop=0 and valid_out=0 during the stall; the burst resumes with the remaining count and the total popped still equals BURST_MAX.
- Starvation: VC1 always non-empty; sched_vc held at 2'b00 with VC0 always non-empty → VC1 is granted once its counter reaches 15, before VC0, even though sched_vc=0.
- Reset mid-burst and enable freeze: assert rst during the second pop cycle → no pop that cycle, state IDLE next edge. Separately, enb=0 during SERVE → pop=0, grant_vc holds, burst continues after enb returns.
